// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
// Holds the FSM state encoding, the byte width and a constant log2 helper.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE
  } uart_arb_state_t;

  // Bits needed to encode value-1, i.e. an index into value entries.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bus shared by N_REQ sources and the arbiter.
// Requesters drive valid/data/last; the arbiter answers with a one-hot ready.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*UART_DW-1:0] req_data;
  logic [N_REQ-1:0]         req_last;
  logic [N_REQ-1:0]         req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting at ptr_i with wrap-around.
// When lock_i is set only lock_idx_i may win, so a packet is never interleaved.
module rr_arbiter import uart_pkg::*; #(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          lock_i,
  input  logic [IW-1:0] lock_idx_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    if (lock_i) begin
      if (req_i[lock_idx_i]) begin
        gnt_o[lock_idx_i] = 1'b1;
        idx_o             = lock_idx_i;
        any_o             = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = IW'((int'(ptr_i) + k) % N);
        if (!any_o && req_i[cand]) begin
          gnt_o[cand] = 1'b1;
          idx_o       = cand;
          any_o       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters: round-robin grant with
// packet locking, one byte per strobe, and a guard on the transmitter start.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter  int N_REQ         = 4,
  parameter  int START_TIMEOUT = 16,
  localparam int IW            = clog2(N_REQ),
  localparam int CW            = clog2(START_TIMEOUT) + 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    req,
  output logic                uart_wr_enb,
  output logic [UART_DW-1:0]  uart_data,
  input  logic                uart_tx_active,
  output logic [IW-1:0]       grant_id,
  output logic                busy,
  output logic                start_err
);

  uart_arb_state_t    state_q;
  logic [UART_DW-1:0] data_q;
  logic               last_q;
  logic               lock_q;
  logic               wr_enb_q;
  logic               start_err_q;
  logic [IW-1:0]      grant_q;
  logic [IW-1:0]      rr_q;
  logic [IW-1:0]      rr_d;
  logic [CW-1:0]      cnt_q;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               arb_en;
  logic               accept;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i      (req.req_valid),
    .ptr_i      (rr_q),
    .lock_i     (lock_q),
    .lock_idx_i (grant_q),
    .gnt_o      (pick_gnt),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  // Ready is combinational, so it is also masked by reset to stay low while reset is held.
  assign arb_en        = reset && (state_q == IDLE) && !uart_tx_active;
  assign req.req_ready = arb_en ? pick_gnt : '0;
  assign accept        = arb_en && pick_any;

  assign rr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      lock_q      <= 1'b0;
      wr_enb_q    <= 1'b0;
      start_err_q <= 1'b0;
      grant_q     <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      wr_enb_q    <= 1'b0;
      start_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q   <= req.req_data[pick_idx*UART_DW +: UART_DW];
            last_q   <= req.req_last[pick_idx];
            grant_q  <= pick_idx;
            wr_enb_q <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          cnt_q   <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (uart_tx_active) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
            // Transmitter never started: drop the byte and release the grant.
            start_err_q <= 1'b1;
            lock_q      <= 1'b0;
            rr_q        <= rr_d;
            state_q     <= IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_active) begin
            state_q <= IDLE;
            if (last_q) begin
              lock_q <= 1'b0;
              rr_q   <= rr_d;
            end else begin
              lock_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_wr_enb = wr_enb_q;
  assign uart_data   = data_q;
  assign grant_id    = grant_q;
  assign start_err   = start_err_q;
  assign busy        = (state_q != IDLE) || lock_q;

endmodule
